// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock first-word-fall-through FIFO.
// Occupancy is tracked by a count register; all status flags derive from it.
// Sticky overflow/underflow flags record dropped writes and pops on empty.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AFULL = DEPTH - 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          clear,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX    = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic          wr_acc;
  logic          rd_acc;

  // Accept decisions and wrapped pointer increments (non-power-of-two safe).
  // A write on full is accepted only alongside a pop; wr_ptr then equals
  // rd_ptr, and the old head is consumed in the same edge it is overwritten.
  always_comb begin
    wr_acc = we && (!full || re);
    rd_acc = re && !empty;
    wr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    rd_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
  end

  // Pointer, occupancy and sticky error-flag registers.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_nxt;
      if (rd_acc) rd_ptr <= rd_nxt;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (!wr_acc && rd_acc) count <= count - 1'b1;
      if (we && full && !re) overflow  <= 1'b1;
      if (re && empty)       underflow <= 1'b1;
    end
  end

  // Storage array; contents survive reset and clear, only pointers move.
  always_ff @(posedge clock) begin
    if (reset_L && !clear && wr_acc) mem[wr_ptr] <= wdata;
  end

  // Status flags from the count register and fall-through head read.
  always_comb begin
    empty       = (count == '0);
    full        = (count == CMAX);
    almost_full = (count >= AFULL_C);
    rdata       = empty ? '0 : mem[rd_ptr];
  end

endmodule
